// File: rtl/frame_rx.sv
// Receive deframer for the 8-lane ADC link: two-stage pipeline, LFSR sequence check, lock FSM.
// Optional lane7 parity check is compiled in with `define FRAME_RX_PARITY_EN.
`timescale 1ns/1ps
module frame_rx #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  lane0,
  input  logic [7:0]  lane1,
  input  logic [7:0]  lane2,
  input  logic [7:0]  lane3,
  input  logic [7:0]  lane4,
  input  logic [7:0]  lane5,
  input  logic [7:0]  lane6,
  input  logic [7:0]  lane7,
  output logic [47:0] adc_data_out,
  output logic        adc_valid,
  output logic        frame_lock,
  output logic        lfrs_err,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [47:0] s1_data_q, s1_data_d;
  logic [3:0]  s1_rx_q, s1_rx_d;
  logic [3:0]  pred_q, pred_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  miss_q, miss_d;
  logic [47:0] adc_data_q, adc_data_d;
  logic        valid_q, valid_d;
  logic        lock_q, lock_d;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        good;

`ifdef FRAME_RX_PARITY_EN
  logic [3:0]  s1_hi_q, s1_hi_d;
  logic [7:0]  s1_lane7_q, s1_lane7_d;
  logic        par_ok;
`else
  logic        unused_lanes;
  assign unused_lanes = ^{lane6[7:4], lane7};
`endif

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  always_comb begin
    s1_data_d  = {lane0, lane1, lane2, lane3, lane4, lane5};
    s1_rx_d    = lane6[3:0];
    good       = (s1_rx_q == pred_q);
`ifdef FRAME_RX_PARITY_EN
    s1_hi_d    = lane6[7:4];
    s1_lane7_d = lane7;
    par_ok     = (s1_lane7_q == (s1_data_q[47:40] ^ s1_data_q[39:32] ^ s1_data_q[31:24] ^
                                 s1_data_q[23:16] ^ s1_data_q[15:8]  ^ s1_data_q[7:0]   ^
                                 {s1_hi_q, s1_rx_q}));
    good       = good && par_ok;
`endif
    state_d    = state_q;
    pred_d     = pred_q;
    cnt_d      = cnt_q;
    miss_d     = miss_q;
    adc_data_d = adc_data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    lock_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      HUNT: begin
        if (s1_rx_q != 4'd0) begin
          pred_d  = lfsr_next(s1_rx_q);
          cnt_d   = 4'd0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (good) begin
          pred_d = lfsr_next(pred_q);
          if (cnt_q == 4'(LOCK_CNT - 1)) begin
            cnt_d   = 4'd0;
            miss_d  = 4'd0;
            state_d = LOCKED;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = 4'd0;
          if (s1_rx_q == 4'd0) state_d = HUNT;
          else                 pred_d  = lfsr_next(s1_rx_q);
        end
      end
      LOCKED: begin
        // Once locked the local LFSR free-runs; received values never reseed it.
        pred_d = lfsr_next(pred_q);
        if (good) begin
          miss_d     = 4'd0;
          valid_d    = 1'b1;
          adc_data_d = s1_data_q;
        end else begin
          err_d = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          if (miss_q == 4'(UNLOCK_CNT - 1)) begin
            miss_d  = 4'd0;
            state_d = HUNT;
          end else begin
            miss_d = miss_q + 4'd1;
          end
        end
        // Lock is reported from the first frame evaluated in LOCKED, so it rises with the first output.
        lock_d = (state_d == LOCKED);
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      s1_data_q  <= '0;
      s1_rx_q    <= '0;
      pred_q     <= '0;
      cnt_q      <= '0;
      miss_q     <= '0;
      adc_data_q <= '0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
`ifdef FRAME_RX_PARITY_EN
      s1_hi_q    <= '0;
      s1_lane7_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      s1_data_q  <= s1_data_d;
      s1_rx_q    <= s1_rx_d;
      pred_q     <= pred_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      adc_data_q <= adc_data_d;
      valid_q    <= valid_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
`ifdef FRAME_RX_PARITY_EN
      s1_hi_q    <= s1_hi_d;
      s1_lane7_q <= s1_lane7_d;
`endif
    end
  end

  assign adc_data_out = adc_data_q;
  assign adc_valid    = valid_q;
  assign frame_lock   = lock_q;
  assign lfrs_err     = err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_frame_rx.sv
// Bench for frame_rx: hand-computed frame table, hand sequences, then randomized stream vs a frame-level model.
`timescale 1ns/1ps
module tb_frame_rx;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 4;
`ifdef FRAME_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int M_HUNT = 0, M_CHECK = 1, M_LOCKED = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  lane0, lane1, lane2, lane3, lane4, lane5, lane6, lane7;
  logic [47:0] adc_data_out;
  logic        adc_valid, frame_lock, lfrs_err;
  logic [15:0] err_cnt;

  frame_rx #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
    .clk(clk), .rst_n(rst_n),
    .lane0(lane0), .lane1(lane1), .lane2(lane2), .lane3(lane3),
    .lane4(lane4), .lane5(lane5), .lane6(lane6), .lane7(lane7),
    .adc_data_out(adc_data_out), .adc_valid(adc_valid), .frame_lock(frame_lock),
    .lfrs_err(lfrs_err), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [47:0] data;
    logic        valid;
    logic        lock;
    logic        err;
    logic [15:0] cnt;
  } out_t;
  localparam int W = $bits(out_t);

  typedef struct {
    logic [47:0] d;
    logic [7:0]  l6;
    bit          flip;
    out_t        e;
  } vec_t;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;

  // Reference model state (frame-level view of the link)
  int          m_mode, m_pred, m_good_run, m_bad_run, m_errs;
  logic [47:0] m_data;

  function automatic int nxt(input int s);
    return ((s * 2) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
  endfunction

  task automatic model_reset();
    m_mode = M_HUNT; m_pred = 0; m_good_run = 0; m_bad_run = 0; m_errs = 0; m_data = '0;
  endtask

  task automatic model_frame(input logic [47:0] d, input int rx, input bit par_ok, output out_t e);
    bit good;
    bit was_locked;
    good       = (rx == m_pred) && (par_ok || !PAR_EN);
    was_locked = (m_mode == M_LOCKED);
    e.valid = 1'b0;
    e.err   = 1'b0;
    if (m_mode == M_HUNT) begin
      if (rx != 0) begin m_pred = nxt(rx); m_good_run = 0; m_mode = M_CHECK; end
    end else if (m_mode == M_CHECK) begin
      if (good) begin
        m_good_run++;
        m_pred = nxt(m_pred);
        if (m_good_run == LOCK_CNT) begin m_mode = M_LOCKED; m_bad_run = 0; end
      end else begin
        m_good_run = 0;
        if (rx == 0) m_mode = M_HUNT;
        else         m_pred = nxt(rx);
      end
    end else begin
      m_pred = nxt(m_pred);
      if (good) begin
        m_bad_run = 0; e.valid = 1'b1; m_data = d;
      end else begin
        e.err = 1'b1;
        m_bad_run++;
        if (m_errs < 65535) m_errs++;
        if (m_bad_run == UNLOCK_CNT) m_mode = M_HUNT;
      end
    end
    e.lock = was_locked && (m_mode == M_LOCKED);
    e.data = m_data;
    e.cnt  = 16'(m_errs);
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s frame %0d: got %h want %h", name, frame_no, got, want);
    end
  endtask

  task automatic compare_front();
    out_t x;
    x = out_t'(exp_q.pop_front());
    check("adc_data_out", adc_data_out, x.data);
    check("adc_valid",    {47'd0, adc_valid},  {47'd0, x.valid});
    check("frame_lock",   {47'd0, frame_lock}, {47'd0, x.lock});
    check("lfrs_err",     {47'd0, lfrs_err},   {47'd0, x.err});
    check("err_cnt",      {32'd0, err_cnt},    {32'd0, x.cnt});
  endtask

  // Driver: one frame per cycle; outputs for a frame appear two edges after it is sampled.
  task automatic run_frame(input logic [47:0] d, input logic [7:0] l6, input bit flip,
                           input bit from_tab, input out_t tab_e);
    out_t e;
    logic [7:0] p;
    @(posedge clk); #1;
    {lane0, lane1, lane2, lane3, lane4, lane5} = d;
    lane6 = l6;
    p = d[47:40] ^ d[39:32] ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ l6;
    lane7 = flip ? (p ^ 8'h01) : p;
    model_frame(d, int'(l6[3:0]), !flip, e);
    if (from_tab) e = tab_e;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 3) compare_front();
    frame_no++;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      compare_front();
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (cycles) begin
      @(posedge clk); #1;
      {lane0, lane1, lane2, lane3} = $urandom;
      {lane4, lane5, lane6, lane7} = $urandom;
      @(negedge clk);
      check("rst_adc_data", adc_data_out, 48'd0);
      check("rst_adc_valid", {47'd0, adc_valid}, 48'd0);
      check("rst_frame_lock", {47'd0, frame_lock}, 48'd0);
      check("rst_lfrs_err", {47'd0, lfrs_err}, 48'd0);
      check("rst_err_cnt", {32'd0, err_cnt}, 48'd0);
    end
    {lane0, lane1, lane2, lane3, lane4, lane5, lane6, lane7} = '0;
    rst_n = 1'b1;
  endtask

  function automatic out_t mk(input logic [47:0] d, input bit v, input bit l, input bit e, input int c);
    out_t o;
    o.data = d; o.valid = v; o.lock = l; o.err = e; o.cnt = 16'(c);
    return o;
  endfunction

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    vec_t tab[20];
    out_t none;
    int tx, burst, nib, r;
    logic [47:0] d;
    logic [7:0]  l6;
    bit          flip;
    none = '0;
    // Lock from seed 1, first output, single error, 4-frame unlock, relock, ignored lane6 upper nibble
    tab[0]  = '{48'h0, 8'h01, 1'b0, mk(48'h0, 0, 0, 0, 0)};
    tab[1]  = '{48'h0, 8'h02, 1'b0, mk(48'h0, 0, 0, 0, 0)};
    tab[2]  = '{48'h0, 8'h04, 1'b0, mk(48'h0, 0, 0, 0, 0)};
    tab[3]  = '{48'h0, 8'h09, 1'b0, mk(48'h0, 0, 0, 0, 0)};
    tab[4]  = '{48'h0, 8'h03, 1'b0, mk(48'h0, 0, 0, 0, 0)};
    tab[5]  = '{48'h0123456789AB, 8'h06, 1'b0, mk(48'h0123456789AB, 1, 1, 0, 0)};
    tab[6]  = '{48'h111111111111, 8'h0D, 1'b0, mk(48'h111111111111, 1, 1, 0, 0)};
    tab[7]  = '{48'h999999999999, 8'h00, 1'b0, mk(48'h111111111111, 0, 1, 1, 1)};
    tab[8]  = '{48'h222222222222, 8'h05, 1'b0, mk(48'h222222222222, 1, 1, 0, 1)};
    tab[9]  = '{48'hAAAAAAAAAAAA, 8'h0A, 1'b0, mk(48'h222222222222, 0, 1, 1, 2)};
    tab[10] = '{48'hAAAAAAAAAAAA, 8'h06, 1'b0, mk(48'h222222222222, 0, 1, 1, 3)};
    tab[11] = '{48'hAAAAAAAAAAAA, 8'h0E, 1'b0, mk(48'h222222222222, 0, 1, 1, 4)};
    tab[12] = '{48'hAAAAAAAAAAAA, 8'h0F, 1'b0, mk(48'h222222222222, 0, 0, 1, 5)};
    tab[13] = '{48'h0, 8'h0C, 1'b0, mk(48'h222222222222, 0, 0, 0, 5)};
    tab[14] = '{48'h0, 8'h08, 1'b0, mk(48'h222222222222, 0, 0, 0, 5)};
    tab[15] = '{48'h0, 8'h01, 1'b0, mk(48'h222222222222, 0, 0, 0, 5)};
    tab[16] = '{48'h0, 8'h02, 1'b0, mk(48'h222222222222, 0, 0, 0, 5)};
    tab[17] = '{48'h0, 8'h04, 1'b0, mk(48'h222222222222, 0, 0, 0, 5)};
    tab[18] = '{48'h333333333333, 8'h09, 1'b0, mk(48'h333333333333, 1, 1, 0, 5)};
    tab[19] = '{48'h444444444444, 8'h53, 1'b0, mk(48'h444444444444, 1, 1, 0, 5)};

    {lane0, lane1, lane2, lane3, lane4, lane5, lane6, lane7} = '0;
    model_reset();
    do_reset(4);
    for (int i = 0; i < 20; i++) run_frame(tab[i].d, tab[i].l6, tab[i].flip, 1'b1, tab[i].e);
    drain();

    // Illegal LFSR value while hunting: must never leave HUNT
    do_reset(2);
    for (int i = 0; i < 6; i++) run_frame({16'($urandom), $urandom}, (i == 5) ? 8'hF0 : 8'h00, 1'b0, 1'b0, none);
    drain();
    check("hunt_illegal_lock", {47'd0, frame_lock}, 48'd0);

    // Parity flip on lane7 while locked
    do_reset(2);
    tx = 1;
    for (int i = 0; i < 6; i++) begin
      run_frame(48'h0123456789AB, 8'(tx), 1'b0, 1'b0, none);
      tx = nxt(tx);
    end
    run_frame(48'hFEDCBA987654, 8'(tx), 1'b1, 1'b0, none);
    drain();
    check("par_lfrs_err", {47'd0, lfrs_err},  {47'd0, PAR_EN});
    check("par_adc_valid", {47'd0, adc_valid}, {47'd0, !PAR_EN});
    check("par_err_cnt", {32'd0, err_cnt}, PAR_EN ? 48'd1 : 48'd0);
    check("par_frame_lock", {47'd0, frame_lock}, 48'd1);

    // Randomized stream against the model
    do_reset(2);
    tx = $urandom_range(1, 15);
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      d = {16'($urandom), $urandom};
      nib = tx;
      tx = nxt(tx);
      r = $urandom_range(0, 99);
      flip = 1'b0;
      if (burst > 0) begin
        nib = nib ^ $urandom_range(1, 15);
        burst--;
      end else if (r < 5)  nib = nib ^ $urandom_range(1, 15);
      else if (r < 8)      nib = 0;
      else if (r < 12)     flip = 1'b1;
      else if (r < 13)     tx = $urandom_range(1, 15);
      if ($urandom_range(0, 149) == 0) burst = $urandom_range(3, 6);
      l6 = {4'($urandom_range(0, 15)), 4'(nib)};
      run_frame(d, l6, flip, 1'b0, none);
      if ($urandom_range(0, 699) == 0) do_reset(2);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
